// File: rtl/mano_ctrl_pkg.sv
// mano_ctrl_pkg: bus select codes, ALU ops, opcodes and the control-word struct for the Mano timing unit
package mano_ctrl_pkg;
    localparam logic [2:0] BUS_SEL_NONE = 3'd0;
    localparam logic [2:0] BUS_SEL_AR   = 3'd1;
    localparam logic [2:0] BUS_SEL_PC   = 3'd2;
    localparam logic [2:0] BUS_SEL_DR   = 3'd3;
    localparam logic [2:0] BUS_SEL_AC   = 3'd4;
    localparam logic [2:0] BUS_SEL_IR   = 3'd5;
    localparam logic [2:0] BUS_SEL_TR   = 3'd6;
    localparam logic [2:0] BUS_SEL_MEM  = 3'd7;

    localparam logic [1:0] ALU_OP_AND  = 2'd0;
    localparam logic [1:0] ALU_OP_ADD  = 2'd1;
    localparam logic [1:0] ALU_OP_PASS = 2'd2;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    typedef struct packed {
        logic [2:0] bus_sel;
        logic [1:0] alu_op;
        logic       ar_ld;
        logic       ar_inc;
        logic       ar_clr;
        logic       pc_ld;
        logic       pc_inc;
        logic       pc_clr;
        logic       dr_ld;
        logic       dr_inc;
        logic       ac_ld;
        logic       ir_ld;
        logic       tr_ld;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_ref;
        logic       io_ref;
        logic       ien_clr;
    } ctrl_t;
endpackage

// File: rtl/mano_seq_counter.sv
// mano_seq_counter: sequence counter with inc/clr/hold and one-hot T decode, parked at 0 while disabled
module mano_seq_counter #(
    parameter int SC_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 inc,
    input  logic                 clr,
    output logic [2**SC_W-1:0]   t
);
    localparam int N = 2**SC_W;

    logic [SC_W-1:0] sc;

    // Count while running; a disabled counter sits at 0 so T0 follows the enabling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sc <= '0;
        else if (!en || clr) sc <= '0;
        else if (inc) sc <= sc + 1'b1;
    end

    assign t = en ? N'(1) << sc : '0;
endmodule

// File: rtl/mano_timing_ctrl.sv
// mano_timing_ctrl: Mano basic-computer timing and control (SC, I, S, optional R via MANO_INTERRUPT_EN)
module mano_timing_ctrl
    import mano_ctrl_pkg::*;
#(
    parameter int SC_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [15:0]          ir,
    input  logic                 dr_zero,
    input  logic                 ien,
    input  logic                 fgi,
    input  logic                 fgo,
    output logic [2:0]           bus_sel,
    output logic                 ar_ld,
    output logic                 ar_inc,
    output logic                 ar_clr,
    output logic                 pc_ld,
    output logic                 pc_inc,
    output logic                 pc_clr,
    output logic                 dr_ld,
    output logic                 dr_inc,
    output logic                 ac_ld,
    output logic                 ir_ld,
    output logic                 tr_ld,
    output logic [1:0]           alu_op,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 reg_ref,
    output logic                 io_ref,
    output logic                 ien_clr,
    output logic [2**SC_W-1:0]   t_state,
    output logic                 running
);
    logic s, i_ff, r, sc_clr, hlt, unused;
    logic [7:0] d;
    logic [2**SC_W-1:0] t;
    ctrl_t c;

    assign d = 8'b1 << ir[14:12];
    assign hlt = t[3] && d[OP_REG] && !i_ff && ir[0];

    mano_seq_counter #(.SC_W(SC_W)) u_sc (
        .clk(clk), .rst_n(rst_n), .en(s), .inc(!sc_clr), .clr(sc_clr), .t(t)
    );

    // Micro-operation decode; any T-state not explicitly continued wraps SC to 0
    always_comb begin
        c = '0;
        sc_clr = 1'b1;
        if (r && t[0]) begin
            c.bus_sel = BUS_SEL_PC;
            c.tr_ld = 1'b1;
            c.ar_clr = 1'b1;
            sc_clr = 1'b0;
        end else if (r && t[1]) begin
            c.bus_sel = BUS_SEL_TR;
            c.mem_wr = 1'b1;
            c.pc_clr = 1'b1;
            sc_clr = 1'b0;
        end else if (r && t[2]) begin
            c.pc_inc = 1'b1;
            c.ien_clr = 1'b1;
        end else if (t[0]) begin
            c.bus_sel = BUS_SEL_PC;
            c.ar_ld = 1'b1;
            sc_clr = 1'b0;
        end else if (t[1]) begin
            c.bus_sel = BUS_SEL_MEM;
            c.mem_rd = 1'b1;
            c.ir_ld = 1'b1;
            c.pc_inc = 1'b1;
            sc_clr = 1'b0;
        end else if (t[2]) begin
            c.bus_sel = BUS_SEL_IR;
            c.ar_ld = 1'b1;
            sc_clr = 1'b0;
        end else if (t[3]) begin
            c.reg_ref = d[OP_REG] && !i_ff;
            c.io_ref = d[OP_REG] && i_ff;
            c.bus_sel = (!d[OP_REG] && i_ff) ? BUS_SEL_MEM : BUS_SEL_NONE;
            c.mem_rd = !d[OP_REG] && i_ff;
            c.ar_ld = !d[OP_REG] && i_ff;
            sc_clr = d[OP_REG];
        end else if (t[4]) begin
            c.bus_sel = (d[OP_AND] || d[OP_ADD] || d[OP_LDA] || d[OP_ISZ]) ? BUS_SEL_MEM :
                        d[OP_STA] ? BUS_SEL_AC : d[OP_BUN] ? BUS_SEL_AR : d[OP_BSA] ? BUS_SEL_PC : BUS_SEL_NONE;
            c.mem_rd = d[OP_AND] || d[OP_ADD] || d[OP_LDA] || d[OP_ISZ];
            c.dr_ld = c.mem_rd;
            c.mem_wr = d[OP_STA] || d[OP_BSA];
            c.pc_ld = d[OP_BUN];
            c.ar_inc = d[OP_BSA];
            sc_clr = !(c.mem_rd || d[OP_BSA]);
        end else if (t[5]) begin
            c.bus_sel = d[OP_LDA] ? BUS_SEL_DR : d[OP_BSA] ? BUS_SEL_AR : BUS_SEL_NONE;
            c.alu_op = d[OP_ADD] ? ALU_OP_ADD : d[OP_LDA] ? ALU_OP_PASS : ALU_OP_AND;
            c.ac_ld = d[OP_AND] || d[OP_ADD] || d[OP_LDA];
            c.pc_ld = d[OP_BSA];
            c.dr_inc = d[OP_ISZ];
            sc_clr = !d[OP_ISZ];
        end else if (t[6]) begin
            c.bus_sel = d[OP_ISZ] ? BUS_SEL_DR : BUS_SEL_NONE;
            c.mem_wr = d[OP_ISZ];
            c.pc_inc = d[OP_ISZ] && dr_zero;
        end
    end

    // S starts on a pulse while idle and drops on HLT; I latches the indirect bit after fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s <= 1'b0;
            i_ff <= 1'b0;
        end else begin
            s <= s ? !hlt : start;
            if (t[2] && !r) i_ff <= ir[15];
        end
    end

`ifdef MANO_INTERRUPT_EN
    // R arms once past decode and is retired at the end of the interrupt cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r <= 1'b0;
        else if (r && t[2]) r <= 1'b0;
        else if (!r && (|t[2**SC_W-1:3]) && ien && (fgi || fgo)) r <= 1'b1;
    end
    assign unused = ^ir[11:1];
`else
    assign r = 1'b0;
    assign unused = ^{ir[11:1], ien, fgi, fgo};
`endif

    assign bus_sel = c.bus_sel;
    assign alu_op = c.alu_op;
    assign ar_ld = c.ar_ld;
    assign ar_inc = c.ar_inc;
    assign ar_clr = c.ar_clr;
    assign pc_ld = c.pc_ld;
    assign pc_inc = c.pc_inc;
    assign pc_clr = c.pc_clr;
    assign dr_ld = c.dr_ld;
    assign dr_inc = c.dr_inc;
    assign ac_ld = c.ac_ld;
    assign ir_ld = c.ir_ld;
    assign tr_ld = c.tr_ld;
    assign mem_rd = c.mem_rd;
    assign mem_wr = c.mem_wr;
    assign reg_ref = c.reg_ref;
    assign io_ref = c.io_ref;
    assign ien_clr = c.ien_clr;
    assign t_state = t;
    assign running = s;
endmodule
